// File: rtl/pixel_window_buffer.sv
// -----------------------------------------------------------------------------
// pixel_window_buffer
//
// Purpose: collects image columns (ROWS pixels each) into a sliding window of
// DEPTH columns and presents the whole window in parallel with a valid/ready
// handshake. col[0] is the oldest column and col[DEPTH-1] the newest. Pixel
// data is never modified; it only moves between registers.
//
// Parameters:
//   PIX_W  bits per pixel
//   ROWS   pixels per input word (one window column)
//   DEPTH  columns held in the window (2..64)
//
// Ports:
//   clock      rising-edge clock
//   reset_L    asynchronous active-low reset
//   clear_L    synchronous active-low clear (beats load and out_ready)
//   load_L     active-low load strobe for `in`
//   in         one column, pixel r at in[r*PIX_W +: PIX_W]
//   out_ready  consumer accepts the current window
//   out_valid  out holds a complete, unconsumed window
//   out        window contents, driven straight from the column registers
//   fill       number of valid columns held, 0..DEPTH
//   overrun    one-cycle pulse after a load was rejected
//
// Handshake: a window is transferred on any edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0 the window is frozen and a
// load is rejected (overrun pulses). A load accepted in the same cycle as a
// transfer slides the window by one column and keeps out_valid high.
//
// Build option: define PIXEL_WINDOW_TRANSPOSE_EN to present `out` row-major
// (pixel (r,c) at (r*DEPTH+c)*PIX_W); otherwise it is column-major as loaded
// (pixel (r,c) at (c*ROWS+r)*PIX_W). Only the output wiring changes.
// -----------------------------------------------------------------------------
module pixel_window_buffer #(
  parameter int PIX_W  = 8,
  parameter int ROWS   = 8,
  parameter int DEPTH  = 15,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset_L,
  input  logic                          clear_L,
  input  logic                          load_L,
  input  logic [ROWS*PIX_W-1:0]         in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [ROWS*DEPTH*PIX_W-1:0]   out,
  output logic [FILL_W-1:0]             fill,
  output logic                          overrun
);

  localparam int                COL_W = ROWS * PIX_W;
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(DEPTH);

  logic [COL_W-1:0]  col_q [DEPTH];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              accept, reject;

  // A held, unconsumed window blocks loads; a consume in the same cycle
  // frees the slot so the load slides the window instead.
  always_comb begin
    accept    = !load_L && clear_L && !(valid_q && !out_ready);
    reject    = !load_L && clear_L && valid_q && !out_ready;

    fill_d    = fill_q;
    valid_d   = valid_q;
    overrun_d = reject;

    if (!clear_L) begin
      fill_d  = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      if (fill_q != FULL) fill_d = fill_q + FILL_W'(1);
      valid_d = (fill_d == FULL);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < DEPTH; k++) col_q[k] <= '0;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (!clear_L) begin
        for (int k = 0; k < DEPTH; k++) col_q[k] <= '0;
      end else if (accept) begin
        // Oldest column drops off col[0]; newest enters at the top.
        for (int k = 0; k < DEPTH - 1; k++) col_q[k] <= col_q[k+1];
        col_q[DEPTH-1] <= in;
      end
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Pure rewiring of the column registers onto the output bus.
  always_comb begin
    out = '0;
    for (int c = 0; c < DEPTH; c++) begin
      for (int r = 0; r < ROWS; r++) begin
`ifdef PIXEL_WINDOW_TRANSPOSE_EN
        out[(r*DEPTH + c)*PIX_W +: PIX_W] = col_q[c][r*PIX_W +: PIX_W];
`else
        out[(c*ROWS + r)*PIX_W +: PIX_W] = col_q[c][r*PIX_W +: PIX_W];
`endif
      end
    end
  end

  assign out_valid = valid_q;
  assign fill      = fill_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_pixel_window_buffer
//
// Directed bench for pixel_window_buffer. Main instance uses the default
// parameters (PIX_W=8, ROWS=8, DEPTH=15); a second instance uses PIX_W=10,
// ROWS=4, DEPTH=2. A small column model supplies every expected window, laid
// out with the same build option as the design.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so each sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_pixel_window_buffer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_L;
  logic         clear_L;
  logic         load_L;
  logic [63:0]  in;
  logic         out_ready;
  logic         out_valid;
  logic [959:0] out;
  logic [3:0]   fill;
  logic         overrun;

  // small-parameter instance
  logic         p_clear_L;
  logic         p_load_L;
  logic [39:0]  p_in;
  logic         p_out_ready;
  logic         p_out_valid;
  logic [79:0]  p_out;
  logic [1:0]   p_fill;
  logic         p_overrun;

  pixel_window_buffer dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .clear_L   (clear_L),
    .load_L    (load_L),
    .in        (in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out       (out),
    .fill      (fill),
    .overrun   (overrun)
  );

  pixel_window_buffer #(.PIX_W(10), .ROWS(4), .DEPTH(2)) dut_small (
    .clock     (clock),
    .reset_L   (reset_L),
    .clear_L   (p_clear_L),
    .load_L    (p_load_L),
    .in        (p_in),
    .out_ready (p_out_ready),
    .out_valid (p_out_valid),
    .out       (p_out),
    .fill      (p_fill),
    .overrun   (p_overrun)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- model ----------------
  logic [63:0] mcol [15];

  function automatic logic [959:0] exp_window();
    logic [959:0] w;
    w = '0;
    for (int c = 0; c < 15; c++) begin
      for (int r = 0; r < 8; r++) begin
`ifdef PIXEL_WINDOW_TRANSPOSE_EN
        w[(r*15 + c)*8 +: 8] = mcol[c][r*8 +: 8];
`else
        w[(c*8 + r)*8 +: 8] = mcol[c][r*8 +: 8];
`endif
      end
    end
    return w;
  endfunction

  function automatic int pix_off(input int r, input int c);
`ifdef PIXEL_WINDOW_TRANSPOSE_EN
    return (r*15 + c)*8;
`else
    return (c*8 + r)*8;
`endif
  endfunction

  task automatic model_push(input logic [63:0] v);
    for (int k = 0; k < 14; k++) mcol[k] = mcol[k+1];
    mcol[14] = v;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 15; k++) mcol[k] = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_L = 1'b0; clear_L = 1'b1; load_L = 1'b1; in = '0; out_ready = 1'b0;
    p_clear_L = 1'b1; p_load_L = 1'b1; p_in = '0; p_out_ready = 1'b0;
    model_clear();
    tick();
    checks++;
    if (out !== '0 || fill !== 4'd0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: fill=%0d valid=%b overrun=%b out_nonzero=%b, want all 0",
               fill, out_valid, overrun, |out);
    end
    checks++;
    if (p_out !== '0 || p_fill !== 2'd0 || p_out_valid !== 1'b0 || p_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_small: fill=%0d valid=%b, want 0", p_fill, p_out_valid);
    end
    // release between edges, with a load already requested
    load_L = 1'b0; in = {8{8'hEE}};
    #3 reset_L = 1'b1;
    load_L = 1'b1;
    tick();
    checks++;
    if (fill !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: fill=%0d, want 0", fill);
    end
  endtask

  task automatic test_fill();
    logic [7:0] b;
    out_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      b = 8'(k);
      in = {8{b}};
      load_L = 1'b0;
      tick();
      model_push({8{b}});
      checks++;
      if (fill !== 4'(k + 1) || out_valid !== (k == 14)) begin
        errors++;
        $display("FAIL fill_step%0d: fill=%0d valid=%b, want fill=%0d valid=%b",
                 k, fill, out_valid, k + 1, (k == 14));
      end
    end
    load_L = 1'b1;
    checks++;
    if (out !== exp_window()) begin
      errors++;
      $display("FAIL full_window: got %h want %h", out, exp_window());
    end
    // spot pixel (row 5, column 9) should equal 9
    checks++;
    if (out[pix_off(5, 9) +: 8] !== 8'd9) begin
      errors++;
      $display("FAIL pixel_r5_c9: got %0h want 9", out[pix_off(5, 9) +: 8]);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    in = {8{8'h55}};
    load_L = 1'b0;
    tick();
    load_L = 1'b1;
    checks++;
    if (overrun !== 1'b1 || fill !== 4'd15 || out_valid !== 1'b1 || out !== exp_window()) begin
      errors++;
      $display("FAIL overrun_pulse: overrun=%b fill=%0d valid=%b out_changed=%b, want 1/15/1/0",
               overrun, fill, out_valid, out !== exp_window());
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || out !== exp_window()) begin
      errors++;
      $display("FAIL overrun_single: overrun=%b, want 0 with window held", overrun);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in = {8{8'hAA}};
    load_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      model_push({8{8'hAA}});
      checks++;
      if (out_valid !== 1'b1 || fill !== 4'd15 || out !== exp_window()) begin
        errors++;
        $display("FAIL slide%0d: valid=%b fill=%0d got %h want %h",
                 i, out_valid, fill, out, exp_window());
      end
    end
    load_L = 1'b1;
    checks++;
    if (out[pix_off(0, 0) +: 8] !== 8'd3 || out[pix_off(7, 12) +: 8] !== 8'hAA) begin
      errors++;
      $display("FAIL slide_ends: col0=%0h col12=%0h, want 3 and aa",
               out[pix_off(0, 0) +: 8], out[pix_off(7, 12) +: 8]);
    end
  endtask

  task automatic test_consume();
    out_ready = 1'b1;
    load_L = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || fill !== 4'd15 || out !== exp_window()) begin
      errors++;
      $display("FAIL consume: valid=%b fill=%0d, want 0 and 15", out_valid, fill);
    end
    out_ready = 1'b0;
    in = {8{8'h11}};
    load_L = 1'b0;
    tick();
    load_L = 1'b1;
    model_push({8{8'h11}});
    checks++;
    if (out_valid !== 1'b1 || fill !== 4'd15 || out !== exp_window()) begin
      errors++;
      $display("FAIL reload: valid=%b fill=%0d got %h want %h", out_valid, fill, out, exp_window());
    end
  endtask

  task automatic test_clear_and_reset();
    logic [7:0] b;
    clear_L = 1'b0;
    tick();
    clear_L = 1'b1;
    model_clear();
    checks++;
    if (fill !== 4'd0 || out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL clear_full: fill=%0d valid=%b out_nonzero=%b, want 0", fill, out_valid, |out);
    end
    for (int k = 0; k < 7; k++) begin
      b = 8'(8'h20 + k);
      in = {8{b}};
      load_L = 1'b0;
      tick();
      model_push({8{b}});
    end
    checks++;
    if (fill !== 4'd7 || out_valid !== 1'b0 || out !== exp_window()) begin
      errors++;
      $display("FAIL partial7: fill=%0d valid=%b got %h want %h", fill, out_valid, out, exp_window());
    end
    // clear wins over a simultaneous load
    in = {8{8'hFF}};
    load_L = 1'b0;
    clear_L = 1'b0;
    tick();
    clear_L = 1'b1;
    model_clear();
    checks++;
    if (fill !== 4'd0 || out !== '0 || overrun !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: fill=%0d overrun=%b out_nonzero=%b, want 0", fill, overrun, |out);
    end
    // three more loads, then reset between edges
    for (int k = 0; k < 3; k++) begin
      in = {8{8'h40}};
      load_L = 1'b0;
      tick();
    end
    load_L = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if (fill !== 4'd0 || out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: fill=%0d out_nonzero=%b, want 0", fill, |out);
    end
    #2 reset_L = 1'b1;
    in = {8{8'h77}};
    load_L = 1'b0;
    tick();
    load_L = 1'b1;
    model_push({8{8'h77}});
    checks++;
    if (fill !== 4'd1 || out_valid !== 1'b0 || out !== exp_window()) begin
      errors++;
      $display("FAIL restart: fill=%0d valid=%b, want 1 and 0", fill, out_valid);
    end
  endtask

  task automatic test_param_sweep();
    logic [39:0] pc [2];
    logic [79:0] pexp;
    pc[0] = {4{10'h3FF}};
    pc[1] = {10'h155, 10'h2AA, 10'h3FF, 10'h000};
    p_out_ready = 1'b0;
    p_in = pc[0];
    p_load_L = 1'b0;
    tick();
    checks++;
    if (p_fill !== 2'd1 || p_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL small_load1: fill=%0d valid=%b, want 1 and 0", p_fill, p_out_valid);
    end
    p_in = pc[1];
    tick();
    p_load_L = 1'b1;
    pexp = '0;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
`ifdef PIXEL_WINDOW_TRANSPOSE_EN
        pexp[(r*2 + c)*10 +: 10] = pc[c][r*10 +: 10];
`else
        pexp[(c*4 + r)*10 +: 10] = pc[c][r*10 +: 10];
`endif
      end
    end
    checks++;
    if (p_fill !== 2'd2 || p_out_valid !== 1'b1 || p_out !== pexp) begin
      errors++;
      $display("FAIL small_window: fill=%0d valid=%b got %h want %h", p_fill, p_out_valid, p_out, pexp);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_fill();
    test_overrun();
    test_back_to_back();
    test_consume();
    test_clear_and_reset();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
